// File: rtl/microcontrolador_pwm_pkg.sv
// Shared register map, CTRL/STATUS bit positions and default widths for the PWM scheduler.
package microcontrolador_pwm_pkg;
    localparam int CHANNELS_DEF = 8;
    localparam int CNT_W_DEF    = 16;
    localparam int PRESC_W_DEF  = 8;

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_PRESC  = 4'd1;
    localparam logic [3:0] ADDR_PERIOD = 4'd2;
    localparam logic [3:0] ADDR_MMASK  = 4'd3;
    localparam logic [3:0] ADDR_MVAL   = 4'd4;
    localparam logic [3:0] ADDR_STATUS = 4'd5;
    localparam logic [3:0] ADDR_DUTY0  = 4'd8;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STATUS_PEND = 0;
endpackage

// File: rtl/microcontrolador_pwm_channel.sv
// One PWM channel: duty shadow/active pair, compare, manual override and pin flop.
// Latency: 1 cycle from cnt/register change to pwm_out. No backpressure.
// Active duty reloads only on load, so a mid-period duty write never glitches the pin.
module microcontrolador_pwm_channel
    import microcontrolador_pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             load,
    input  logic             duty_we,
    input  logic [CNT_W-1:0] wdata,
    input  logic [CNT_W-1:0] cnt,
    input  logic             mmask,
    input  logic             mval,
    output logic             pwm_out,
    output logic [CNT_W-1:0] duty_sh
);
    logic [CNT_W-1:0] duty_act;
    logic             pwm_cmp;

    assign pwm_cmp = run && (cnt < duty_act);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_sh  <= '0;
            duty_act <= '0;
            pwm_out  <= 1'b0;
        end else begin
            if (duty_we) duty_sh <= wdata;
            // load samples the pre-write shadow when a write lands on the wrap cycle
            if (load) duty_act <= duty_sh;
            pwm_out <= mmask ? mval : pwm_cmp;
        end
    end
endmodule

// File: rtl/microcontrolador_pwm_scheduler.sv
// Avalon-MM PWM generator: bus decode, shared prescaler/period counter, wrap, IRQ, readdata.
// Latency: writes land next edge, pins 1 cycle after cnt; readdata combinational, zero wait states.
// No backpressure. Optional period-wrap interrupt is built only with PWM_IRQ_EN defined.
module microcontrolador_pwm_scheduler
    import microcontrolador_pwm_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int PRESC_W  = PRESC_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [3:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                irq
);
    logic               wr;
    logic               run;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_cnt;
    logic [CNT_W-1:0]   period_sh;
    logic [CNT_W-1:0]   period_act;
    logic [CNT_W-1:0]   cnt;
    logic [CHANNELS-1:0] mmask;
    logic [CHANNELS-1:0] mval;
    logic               tick;
    logic               wrap;
    logic               load;
    logic               irq_en;
    logic               pending;
    logic [CNT_W-1:0]   duty_rd [8];
    logic               unused_wdata;

    assign wr   = chipselect && !write_n;
    assign tick = run && (presc_cnt == presc);
    assign wrap = tick && (cnt == period_act);
    // While stopped the active copies follow the shadows so RUN starts with fresh values
    assign load = wrap || !run;
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run        <= 1'b0;
            presc      <= '0;
            presc_cnt  <= '0;
            period_sh  <= '0;
            period_act <= '0;
            cnt        <= '0;
            mmask      <= '0;
            mval       <= '0;
        end else begin
            if (wr && address == ADDR_CTRL)   run       <= writedata[CTRL_RUN];
            if (wr && address == ADDR_PRESC)  presc     <= writedata[PRESC_W-1:0];
            if (wr && address == ADDR_PERIOD) period_sh <= writedata[CNT_W-1:0];
            if (wr && address == ADDR_MMASK)  mmask     <= writedata[CHANNELS-1:0];
            if (wr && address == ADDR_MVAL)   mval      <= writedata[CHANNELS-1:0];

            // >= also catches a PRESC shrunk below presc_cnt: wrap to 0 with no tick
            if (!run || presc_cnt >= presc) presc_cnt <= '0;
            else                            presc_cnt <= presc_cnt + 1'b1;

            if (!run)      cnt <= '0;
            else if (wrap) cnt <= '0;
            else if (tick) cnt <= cnt + 1'b1;

            if (load) period_act <= period_sh;
        end
    end

`ifdef PWM_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en  <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (wr && address == ADDR_CTRL) irq_en <= writedata[CTRL_IRQ_EN];
            if (wrap && irq_en)
                pending <= 1'b1;
            else if (wr && address == ADDR_STATUS && writedata[STATUS_PEND])
                pending <= 1'b0;
        end
    end
    assign irq = pending;
`else
    assign irq_en  = 1'b0;
    assign pending = 1'b0;
    assign irq     = 1'b0;
`endif

    for (genvar i = 0; i < 8; i++) begin : g_ch
        if (i < CHANNELS) begin : g_on
            microcontrolador_pwm_channel #(.CNT_W(CNT_W)) u_ch (
                .clk     (clk),
                .reset_n (reset_n),
                .run     (run),
                .load    (load),
                .duty_we (wr && address == 4'(ADDR_DUTY0 + i)),
                .wdata   (writedata[CNT_W-1:0]),
                .cnt     (cnt),
                .mmask   (mmask[i]),
                .mval    (mval[i]),
                .pwm_out (pwm_out[i]),
                .duty_sh (duty_rd[i])
            );
        end else begin : g_off
            assign duty_rd[i] = '0;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_RUN]    = run;
                readdata[CTRL_IRQ_EN] = irq_en;
            end
            ADDR_PRESC:  readdata = 32'(presc);
            ADDR_PERIOD: readdata = 32'(period_sh);
            ADDR_MMASK:  readdata = 32'(mmask);
            ADDR_MVAL:   readdata = 32'(mval);
            ADDR_STATUS: begin
                readdata[STATUS_PEND] = pending;
                readdata[31:16]       = 16'(cnt);
            end
            default: begin
                if (address[3] && int'(address[2:0]) < CHANNELS)
                    readdata = 32'(duty_rd[address[2:0]]);
            end
        endcase
    end
endmodule

// File: tb/tb_microcontrolador_pwm_scheduler.sv
// Self-checking bench for microcontrolador_pwm_scheduler; expected pin/counter values are queued
// at stimulus time and popped on each falling edge.
module tb_microcontrolador_pwm_scheduler;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  pwm_out;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [7:0] mask;
        logic [7:0] val;
    } exp_t;

    exp_t        pwm_q[$];
    logic [15:0] cnt_q[$];

    microcontrolador_pwm_scheduler #(.CHANNELS(8), .CNT_W(16), .PRESC_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .pwm_out    (pwm_out),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        pwm_q.delete();
        cnt_q.delete();
    endtask

    // Returns on the falling edge right after the capturing rising edge
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        #1 d = readdata;
    endtask

    task automatic push(input logic [7:0] m, input logic [7:0] v);
        exp_t e;
        e.mask = m;
        e.val  = v;
        pwm_q.push_back(e);
    endtask

    task automatic sb_run(input int n, input bit chk_cnt);
        exp_t e;
        logic [15:0] c;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            n_tests++;
            if (pwm_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty sample %0d: no expected pwm entry", k);
            end else begin
                e = pwm_q.pop_front();
                if ((pwm_out & e.mask) !== e.val) begin
                    n_fail++;
                    $display("FAIL pwm sample %0d: got %02h (mask %02h) want %02h", k,
                             pwm_out & e.mask, e.mask, e.val);
                end
            end
            if (chk_cnt) begin
                n_tests++;
                c = cnt_q.pop_front();
                if (readdata[31:16] !== c) begin
                    n_fail++;
                    $display("FAIL status_cnt sample %0d: got %0d want %0d", k, readdata[31:16], c);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        n_tests++;
        if (pwm_out !== 8'h00 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pins: pwm=%02h irq=%b want 00/0", pwm_out, irq);
        end
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), d);
            n_tests++;
            if (d !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_reg addr %0d: got %08h want 00000000", a, d);
            end
        end
        chipselect = 1'b0;
    endtask

    task automatic test_basic_pwm();
        do_reset();
        bus_write(4'd2, 32'd9);
        bus_write(4'd8, 32'd3);
        bus_write(4'd0, 32'h1);
        for (int k = 1; k <= 30; k++) push(8'h01, {7'd0, ((k - 1) % 10) < 3});
        sb_run(30, 1'b0);
    endtask

    task automatic test_duty_update();
        logic [31:0] d;
        do_reset();
        bus_write(4'd2, 32'd9);
        bus_write(4'd8, 32'd3);
        bus_write(4'd0, 32'h1);
        // DUTY0=7 captured mid-period (cnt becomes 5); takes effect from the wrap 10 cycles after RUN
        for (int k = 1; k <= 30; k++)
            push(8'h01, {7'd0, (k <= 10) ? (((k - 1) % 10) < 3) : (((k - 1) % 10) < 7)});
        fork
            sb_run(30, 1'b0);
            begin
                repeat (3) @(negedge clk);
                bus_write(4'd8, 32'd7);
            end
        join
        bus_read(4'd8, d);
        n_tests++;
        if (d !== 32'd7) begin
            n_fail++;
            $display("FAIL duty0_readback: got %0d want 7", d);
        end
        chipselect = 1'b0;
    endtask

    task automatic test_edge_duties();
        do_reset();
        bus_write(4'd2, 32'd9);
        bus_write(4'd9, 32'd0);
        bus_write(4'd10, 32'd10);
        bus_write(4'd11, 32'hFFFF);
        bus_write(4'd0, 32'h1);
        for (int k = 1; k <= 20; k++) push(8'h0E, 8'h0C);
        sb_run(20, 1'b0);

        do_reset();
        bus_write(4'd2, 32'd0);
        bus_write(4'd11, 32'd1);
        bus_write(4'd0, 32'h1);
        chipselect = 1'b1;
        address    = 4'd5;
        for (int k = 1; k <= 10; k++) begin
            push(8'h08, 8'h08);
            cnt_q.push_back(16'd0);
        end
        sb_run(10, 1'b1);
        chipselect = 1'b0;
    endtask

    task automatic test_prescaler();
        do_reset();
        bus_write(4'd1, 32'd3);
        bus_write(4'd2, 32'd4);
        bus_write(4'd8, 32'd2);
        bus_write(4'd0, 32'h1);
        chipselect = 1'b1;
        address    = 4'd5;
        for (int k = 1; k <= 40; k++) begin
            push(8'h01, {7'd0, (((k - 1) / 4) % 5) < 2});
            cnt_q.push_back(16'((k / 4) % 5));
        end
        sb_run(40, 1'b1);
        chipselect = 1'b0;
    endtask

    task automatic test_manual();
        logic [31:0] d;
        do_reset();
        bus_write(4'd3, 32'h01);
        bus_write(4'd4, 32'h01);
        push(8'hFF, 8'h01);
        sb_run(1, 1'b0);
        bus_write(4'd3, 32'h00);
        n_tests++;
        if (pwm_out !== 8'h01) begin
            n_fail++;
            $display("FAIL mmask_latency: got %02h want 01", pwm_out);
        end
        push(8'hFF, 8'h00);
        sb_run(1, 1'b0);

        bus_write(4'd2, 32'd9);
        bus_write(4'd8, 32'd5);
        bus_write(4'd3, 32'hF0);
        bus_write(4'd4, 32'hF0);
        bus_write(4'd0, 32'h1);
        repeat (3) @(negedge clk);
        n_tests++;
        if (pwm_out !== 8'hF1) begin
            n_fail++;
            $display("FAIL mixed_pins: got %02h want f1", pwm_out);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (pwm_out !== 8'h00 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: pwm=%02h irq=%b want 00/0", pwm_out, irq);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(4'd3, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL mmask_after_reset: got %08h want 0", d);
        end
        chipselect = 1'b0;
    endtask

    task automatic test_irq();
        logic [31:0] d;
        do_reset();
        bus_write(4'd2, 32'd4);
        bus_write(4'd0, 32'h3);
`ifdef PWM_IRQ_EN
        // First wrap on the 5th edge after RUN; pending is visible right after it
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_tests++;
            if (irq !== (k >= 5)) begin
                n_fail++;
                $display("FAIL irq_rise sample %0d: got %b want %b", k, irq, k >= 5);
            end
        end
        bus_read(4'd5, d);
        n_tests++;
        if (d[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL status_pending: got %b want 1", d[0]);
        end
        chipselect = 1'b0;
        repeat (2) @(negedge clk);
        bus_write(4'd5, 32'h1);
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_set_wins: got %b want 1", irq);
        end
        bus_write(4'd5, 32'h1);
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_w1c: got %b want 0", irq);
        end
`else
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_tests++;
            if (irq !== 1'b0) begin
                n_fail++;
                $display("FAIL irq_tied sample %0d: got %b want 0", k, irq);
            end
        end
        bus_read(4'd0, d);
        n_tests++;
        if (d !== 32'h1) begin
            n_fail++;
            $display("FAIL ctrl_irq_en_ignored: got %08h want 00000001", d);
        end
        bus_read(4'd5, d);
        n_tests++;
        if (d[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL status_pending_tied: got %b want 0", d[0]);
        end
        chipselect = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_basic_pwm();
        test_duty_update();
        test_edge_duties();
        test_prescaler();
        test_manual();
        test_irq();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
